// File: rtl/counter_pkg.sv
// Shared types for the programmable counter family.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } cnt_mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: emits one tick every presc+1 enabled cycles.
module counter_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Next prescaler value and tick; restart also covers DONE, where holding at
  // zero is indistinguishable from freezing since leaving DONE zeroes it anyway.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == presc) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/saturate/one-shot modes,
// terminal-count pulse and compare-match output.
module prog_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   count_out,
  output logic               tc_pulse,
  output logic               cmp_match,
  output logic               done
);

  logic [WIDTH-1:0] count_q, count_d;
  cnt_state_e       state_q, state_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] sat_tgt;
  logic [WIDTH-1:0] sat_next;

  counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .presc   (presc),
    .restart (clr | load | (state_q != ST_RUN)),
    .tick    (tick)
  );

  // Next count, state and terminal pulse; clr > load > tick.
  always_comb begin
    count_d  = count_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    at_term  = dir ? (count_q >= limit) : (count_q == '0);
    step     = dir ? (count_q + 1'b1) : (count_q - 1'b1);
    sat_tgt  = dir ? limit : '0;
    sat_next = at_term ? sat_tgt : step;
    if (clr) begin
      count_d = '0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = load_val;
      state_d = ST_RUN;
    end else if (tick) begin
      case (mode)
        MODE_SAT: begin
          // Pulse only when arriving on the rail, including a clamp from above limit.
          count_d = sat_next;
          tc_d    = (sat_next == sat_tgt) && (count_q != sat_tgt);
        end
        MODE_ONESHOT: begin
          if (at_term) begin
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d = step;
          end
        end
        default: begin
          if (at_term) begin
            count_d = dir ? '0 : limit;
            tc_d    = 1'b1;
          end else begin
            count_d = step;
          end
        end
      endcase
    end
  end

  // Count, FSM state and terminal pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state_q <= ST_RUN;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  assign count_out = count_q;
  assign tc_pulse  = tc_q;
  assign done      = (state_q == ST_DONE);
  assign cmp_match = (count_q == cmp_val);

endmodule
